// File: rtl/sprite_rom_sequencer.sv
// sprite_rom_sequencer
// Walks a SPRITE_W x SPRITE_H sprite held in one of several ROMs. For each
// pixel it issues a single ROM read request and waits for the reader's ready
// pulse. It then offers the returned word, together with its screen
// coordinates, to the LCD pixel-write stage through a valid/ready handshake.
//
// Optional feature: define SPRITE_TRANSP_EN to enable colour keying. A ROM
// word equal to TRANSP_COLOUR is then skipped, and no pixel_write is issued
// for it. With the macro undefined, every pixel is written.
//
// All outputs come straight from flops. They are loaded from the next-state
// decode, so each output lines up with the state it belongs to.

module sprite_rom_sequencer #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int ROM_SEL_W = 2,
  parameter int X_W = 8,
  parameter int Y_W = 9,
  parameter logic [DATA_W-1:0] TRANSP_COLOUR = 16'hF81F
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROM_SEL_W-1:0] sprite_sel,
  input  logic [X_W-1:0]       origin_x,
  input  logic [Y_W-1:0]       origin_y,
  output logic [ROM_SEL_W-1:0] rom_sel,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 rom_req,
  input  logic [DATA_W-1:0]    rom_data,
  input  logic                 rom_ready,
  output logic [X_W-1:0]       pixel_x,
  output logic [Y_W-1:0]       pixel_y,
  output logic [DATA_W-1:0]    pixel_data,
  output logic                 pixel_write,
  input  logic                 pixel_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

`ifdef SPRITE_TRANSP_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_nxt;
  logic [X_W-1:0]   org_x;
  logic [Y_W-1:0]   org_y;

  logic             load;
  logic             capture;
  logic             col_end;
  logic             last_pix;
  logic             is_key;
  logic [COL_W-1:0] col_adv;
  logic [ROW_W-1:0] row_adv;
  logic [ADDR_W-1:0] addr_nxt;

  // Position bookkeeping: wrap the column at the row end and detect the final pixel.
  assign col_end  = (col == COL_W'(SPRITE_W - 1));
  assign last_pix = col_end && (row == ROW_W'(SPRITE_H - 1));
  assign col_adv  = col_end ? {COL_W{1'b0}} : col + 1'b1;
  assign row_adv  = col_end ? row + 1'b1 : row;

  // The key compare exists in both builds. It is only acted on when keying is enabled.
  assign is_key = TRANSP_EN && (rom_data == TRANSP_COLOUR);

  // Linear ROM address of the pixel about to be requested. It is truncated to the ROM width.
  assign addr_nxt = ADDR_W'(32'(row_nxt) * SPRITE_W + 32'(col_nxt));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, draw-position update and capture/load strobes.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          col_nxt   = {COL_W{1'b0}};
          row_nxt   = {ROW_W{1'b0}};
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rom_ready) begin
          if (is_key) begin
            if (last_pix) begin
              state_nxt = S_DONE;
            end else begin
              col_nxt   = col_adv;
              row_nxt   = row_adv;
              state_nxt = S_REQ;
            end
          end else begin
            capture   = 1'b1;
            state_nxt = S_WRITE;
          end
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WRITE: begin
        if (pixel_ready) begin
          if (last_pix) begin
            state_nxt = S_DONE;
          end else begin
            col_nxt   = col_adv;
            row_nxt   = row_adv;
            state_nxt = S_REQ;
          end
        end else begin
          state_nxt = S_WRITE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. Reset clears everything, including any pending pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      col         <= {COL_W{1'b0}};
      row         <= {ROW_W{1'b0}};
      org_x       <= {X_W{1'b0}};
      org_y       <= {Y_W{1'b0}};
      rom_sel     <= {ROM_SEL_W{1'b0}};
      rom_addr    <= {ADDR_W{1'b0}};
      rom_req     <= 1'b0;
      pixel_x     <= {X_W{1'b0}};
      pixel_y     <= {Y_W{1'b0}};
      pixel_data  <= {DATA_W{1'b0}};
      pixel_write <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      col         <= col_nxt;
      row         <= row_nxt;
      rom_req     <= (state_nxt == S_REQ);
      pixel_write <= (state_nxt == S_WRITE);
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_DONE);
      if (load) begin
        rom_sel <= sprite_sel;
        org_x   <= origin_x;
        org_y   <= origin_y;
      end
      if (state_nxt == S_REQ) begin
        rom_addr <= addr_nxt;
      end
      if (capture) begin
        pixel_data <= rom_data;
        pixel_x    <= org_x + X_W'(col);
        pixel_y    <= org_y + Y_W'(row);
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_sequencer.sv
// Directed bench for sprite_rom_sequencer, built as a 2x2 sprite.
// A ROM model answers each request one cycle later. Expected addresses and
// pixels are queued when a draw is started, and are popped as the DUT
// produces them.

module tb_sprite_rom_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] sprite_sel;
  logic [7:0] origin_x;
  logic [8:0] origin_y;
  logic [1:0] rom_sel;
  logic [7:0] rom_addr;
  logic       rom_req;
  logic [15:0] rom_data;
  logic       rom_ready;
  logic [7:0] pixel_x;
  logic [8:0] pixel_y;
  logic [15:0] pixel_data;
  logic       pixel_write;
  logic       pixel_ready;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]  exp_addr[$];
  logic [32:0] exp_pix[$];

  bit         rom_pend = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  logic [1:0] pend_sel = 2'b00;
  logic [1:0] cur_sel = 2'b00;
  int         key_addr = -1;
  int         stall_at = -1;
  bit         stall_used = 1'b0;
  int         stall_left = 0;
  bit         have_held = 1'b0;
  logic [32:0] held = 33'h0;
  int         n_xfer = 0;
  int         done_seen = 0;
  int         done_c = 0;

  always #5 clk = ~clk;

  sprite_rom_sequencer #(
    .SPRITE_W(2), .SPRITE_H(2), .ADDR_W(8), .DATA_W(16),
    .ROM_SEL_W(2), .X_W(8), .Y_W(9)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .sprite_sel(sprite_sel),
    .origin_x(origin_x), .origin_y(origin_y), .rom_sel(rom_sel),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_data(rom_data),
    .rom_ready(rom_ready), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_data(pixel_data), .pixel_write(pixel_write),
    .pixel_ready(pixel_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rom_word(input logic [1:0] s, input logic [7:0] a);
    if (int'(a) == key_addr) return 16'hF81F;
    return {4'hA, s, 2'b01, a};
  endfunction

  // One clock: sample at the falling edge, run the models, then drive the next inputs.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (rom_pend) begin
      rom_ready = 1'b1;
      rom_data  = rom_word(pend_sel, pend_addr);
      rom_pend  = 1'b0;
    end else begin
      rom_ready = 1'b0;
      rom_data  = 16'h5A5A;
    end
    if (rom_req) begin
      if (exp_addr.size() == 0) begin
        chk("addr_unexpected", 64'(rom_addr), 64'hFFFF);
      end else begin
        chk("rom_addr", 64'(rom_addr), 64'(exp_addr.pop_front()));
      end
      chk("rom_sel", 64'(rom_sel), 64'(cur_sel));
      rom_pend  = 1'b1;
      pend_addr = rom_addr;
      pend_sel  = rom_sel;
    end
    if (pixel_write) begin
      if (n_xfer == stall_at && !stall_used) begin
        stall_left = 5;
        stall_used = 1'b1;
      end
      if (have_held) chk("pixel_hold", 64'({pixel_x, pixel_y, pixel_data}), 64'(held));
      if (stall_left > 0) begin
        pixel_ready = 1'b0;
        stall_left--;
        held = {pixel_x, pixel_y, pixel_data};
        have_held = 1'b1;
        chk("no_req_in_stall", 64'(rom_req), 64'd0);
      end else begin
        pixel_ready = 1'b1;
        have_held = 1'b0;
        n_xfer++;
        if (exp_pix.size() == 0) begin
          chk("pix_unexpected", 64'({pixel_x, pixel_y, pixel_data}), 64'h1FFFFFFFF);
        end else begin
          chk("pixel", 64'({pixel_x, pixel_y, pixel_data}), 64'(exp_pix.pop_front()));
        end
      end
    end else begin
      pixel_ready = 1'b1;
    end
    if (done) begin
      done_seen++;
      done_c = cyc;
    end
  endtask

  task automatic draw(input logic [7:0] ox, input logic [8:0] oy, input logic [1:0] sel,
                      input int stall_pix, input int key_a, input bit mid_start,
                      input int exp_lat, input int exp_xfer);
    int start_c;
    key_addr   = key_a;
    stall_at   = stall_pix;
    stall_used = 1'b0;
    stall_left = 0;
    have_held  = 1'b0;
    n_xfer     = 0;
    done_seen  = 0;
    cur_sel    = sel;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ex;
      logic [8:0] ey;
      ex = ox + 8'(i % 2);
      ey = oy + 9'(i / 2);
      exp_addr.push_back(8'(i));
`ifdef SPRITE_TRANSP_EN
      if (i != key_a) exp_pix.push_back({ex, ey, rom_word(sel, 8'(i))});
`else
      exp_pix.push_back({ex, ey, rom_word(sel, 8'(i))});
`endif
    end
    start      = 1'b1;
    sprite_sel = sel;
    origin_x   = ox;
    origin_y   = oy;
    start_c    = cyc;
    cycle();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < 300 && done_seen == 0; i++) begin
      cycle();
      if (mid_start && cyc == start_c + 5) begin
        start      = 1'b1;
        sprite_sel = 2'd0;
        origin_x   = 8'h40;
        origin_y   = 9'h040;
      end else begin
        start = 1'b0;
      end
    end
    if (done_seen == 0) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      chk("busy_in_done", 64'(busy), 64'd1);
      chk("done_latency", 64'(done_c - start_c), 64'(exp_lat));
    end
    start = 1'b0;
    cycle();
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    cycle();
    chk("done_count", 64'(done_seen), 64'd1);
    chk("addr_left", 64'(exp_addr.size()), 64'd0);
    chk("pix_left", 64'(exp_pix.size()), 64'd0);
    chk("xfer_count", 64'(n_xfer), 64'(exp_xfer));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    sprite_sel  = 2'd0;
    origin_x    = 8'h00;
    origin_y    = 9'h000;
    rom_data    = 16'h0000;
    rom_ready   = 1'b0;
    pixel_ready = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;

    // Reset state
    chk("rst_rom_sel", 64'(rom_sel), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_rom_req", 64'(rom_req), 64'd0);
    chk("rst_pixel_x", 64'(pixel_x), 64'd0);
    chk("rst_pixel_y", 64'(pixel_y), 64'd0);
    chk("rst_pixel_data", 64'(pixel_data), 64'd0);
    chk("rst_pixel_write", 64'(pixel_write), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Idle with start low
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_req", 64'(rom_req), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end

    // Basic 2x2 draw at (10,20)
    draw(8'd10, 9'd20, 2'd1, -1, -1, 1'b0, 13, 4);
    // Pixel 1 back-pressured for 5 cycles
    draw(8'd100, 9'd200, 2'd2, 1, -1, 1'b0, 18, 4);
    // X and Y wrap, with a start pulse mid-draw that must be ignored
    draw(8'd255, 9'd511, 2'd3, -1, -1, 1'b1, 13, 4);
    // ROM word 1 equals the colour key
`ifdef SPRITE_TRANSP_EN
    draw(8'd10, 9'd20, 2'd0, -1, 1, 1'b0, 12, 3);
`else
    draw(8'd10, 9'd20, 2'd0, -1, 1, 1'b0, 13, 4);
`endif
    key_addr = -1;

    // Reset while waiting on the ROM
    start = 1'b1;
    sprite_sel = 2'd1;
    origin_x = 8'd3;
    origin_y = 9'd4;
    cur_sel = 2'd1;
    exp_addr.push_back(8'd0);
    done_seen = 0;
    cycle();
    start = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_req", 64'(rom_req), 64'd0);
    chk("rstmid_write", 64'(pixel_write), 64'd0);
    reset = 1'b0;
    exp_addr.delete();
    exp_pix.delete();
    rom_pend = 1'b0;
    repeat (5) cycle();
    chk("rstmid_no_done", 64'(done_seen), 64'd0);
    chk("rstmid_idle_busy", 64'(busy), 64'd0);

    // Recovery draw after the mid-draw reset
    draw(8'd0, 9'd0, 2'd1, -1, -1, 1'b0, 13, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
